// File: rtl/ac97_ctlif_mc.sv
`default_nettype none
// ============================================================================
// ac97_ctlif_mc : AC'97 codec register access plus multi-channel DMA control
// Rev 1.0
// ============================================================================
module ac97_ctlif_mc #(
  parameter logic [3:0] csr_addr = 4'h0,
  parameter int         channels = 2,
  parameter int         count_w  = 16
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic [13:0]                 csr_a,
  input  logic                        csr_we,
  input  logic [31:0]                 csr_di,
  output logic [31:0]                 csr_do,
  output logic                        irq,
  input  logic                        down_en,
  input  logic                        down_next_frame,
  output logic                        down_addr_valid,
  output logic [19:0]                 down_addr,
  output logic                        down_data_valid,
  output logic [19:0]                 down_data,
  input  logic                        up_en,
  input  logic                        up_next_frame,
  input  logic                        up_frame_valid,
  input  logic                        up_addr_valid,
  input  logic                        up_data_valid,
  input  logic [19:0]                 up_addr,
  input  logic [19:0]                 up_data,
  output logic [channels-1:0]         dma_en,
  output logic [channels*30-1:0]      dma_addr,
  output logic [channels*count_w-1:0] dma_remaining,
  input  logic [channels-1:0]         dma_next
);

  localparam int                 SW        = channels + 2;
  localparam logic [count_w-1:0] C_REM_ONE = 1;

  logic               r_pending, r_write;
  logic [6:0]         r_req_addr;
  logic [15:0]        r_req_data, r_reply;
  logic [SW-1:0]      r_status, r_mask;
  logic [31:0]        r_csr_do;
  logic               r_irq, r_down_av, r_down_dv;
  logic [19:0]        r_down_a, r_down_d;
  logic [29:0]        r_addr   [channels];
  logic [29:0]        r_base   [channels];
  logic [count_w-1:0] r_rem    [channels];
  logic [count_w-1:0] r_reload [channels];
  logic [channels-1:0] r_en, r_loop;

  logic                w_sel, w_wr, w_down, w_up, w_unused;
  logic [9:0]          w_off;
  logic [channels-1:0] w_ch_wr, w_fin;
  logic [SW-1:0]       w_set, w_clr;
  logic [31:0]         w_rdata;

  assign w_sel    = (csr_a[13:10] == csr_addr);
  assign w_off    = csr_a[9:0];
  assign w_wr     = csr_we & w_sel;
  assign w_down   = down_en & down_next_frame;
  assign w_up     = up_en & up_next_frame & up_frame_valid & up_addr_valid & up_data_valid;
  assign w_unused = ^{up_addr, up_data[3:0]};

  // Base register (offset +3) is read-only, so writes to it do not pre-empt dma_next.
  always_comb begin
    w_ch_wr = '0;
    w_fin   = '0;
    for (int k = 0; k < channels; k++) begin
      w_ch_wr[k] = w_wr && (w_off[9:2] == 8'(4 + k)) && (w_off[1:0] != 2'd3);
      w_fin[k]   = dma_next[k] && !w_ch_wr[k] && (r_rem[k] == C_REM_ONE);
    end
  end

  assign w_set = {w_fin, w_up, w_down & r_pending};
  assign w_clr = (w_wr && w_off == 10'h004) ? csr_di[SW-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      case (w_off)
        10'h000: w_rdata = {30'd0, r_write, r_pending};
        10'h001: w_rdata = {25'd0, r_req_addr};
        10'h002: w_rdata = {16'd0, r_req_data};
        10'h003: w_rdata = {16'd0, r_reply};
        10'h004: w_rdata = 32'(r_status);
        10'h005: w_rdata = 32'(r_mask);
        default: ;
      endcase
      for (int k = 0; k < channels; k++) begin
        if (w_off[9:2] == 8'(4 + k)) begin
          case (w_off[1:0])
            2'd0: w_rdata = {30'd0, r_loop[k], r_en[k]};
            2'd1: w_rdata = {r_addr[k], 2'b00};
            2'd2: w_rdata = 32'({r_rem[k], 2'b00});
            2'd3: w_rdata = {r_base[k], 2'b00};
          endcase
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pending  <= 1'b0;
      r_write    <= 1'b0;
      r_req_addr <= '0;
      r_req_data <= '0;
      r_reply    <= '0;
      r_status   <= '0;
      r_mask     <= '0;
      r_csr_do   <= '0;
      r_irq      <= 1'b0;
      r_down_av  <= 1'b0;
      r_down_dv  <= 1'b0;
      r_down_a   <= '0;
      r_down_d   <= '0;
      r_en       <= '0;
      r_loop     <= '0;
      for (int k = 0; k < channels; k++) begin
        r_addr[k]   <= '0;
        r_base[k]   <= '0;
        r_rem[k]    <= '0;
        r_reload[k] <= '0;
      end
    end else begin
      r_csr_do <= w_rdata;
      r_irq    <= |(r_status & r_mask);
      r_status <= (r_status & ~w_clr) | w_set;

      if (w_wr && w_off == 10'h001) r_req_addr <= csr_di[6:0];
      if (w_wr && w_off == 10'h002) r_req_data <= csr_di[15:0];
      if (w_wr && w_off == 10'h005) r_mask     <= csr_di[SW-1:0];
      if (w_up)                     r_reply    <= up_data[19:4];

      // A software write of ctl wins over the frame strobe consuming the request.
      if (w_wr && w_off == 10'h000) begin
        r_pending <= csr_di[0];
        r_write   <= csr_di[1];
      end else if (w_down) begin
        r_pending <= 1'b0;
      end

      if (w_down) begin
        r_down_av <= r_pending;
        r_down_a  <= r_pending ? {~r_write, r_req_addr, 12'd0} : '0;
        r_down_dv <= r_pending & r_write;
        r_down_d  <= (r_pending & r_write) ? {r_req_data, 4'd0} : '0;
      end

      for (int k = 0; k < channels; k++) begin
        if (w_ch_wr[k]) begin
          case (w_off[1:0])
            2'd0: begin
              r_en[k]   <= csr_di[0];
              r_loop[k] <= csr_di[1];
            end
            2'd1: begin
              r_addr[k] <= csr_di[31:2];
              r_base[k] <= csr_di[31:2];
            end
            2'd2: begin
              r_rem[k]    <= csr_di[count_w+1:2];
              r_reload[k] <= csr_di[count_w+1:2];
            end
            default: ;
          endcase
        end else if (dma_next[k] && r_rem[k] != '0) begin
          if (w_fin[k]) begin
            if (r_loop[k]) begin
              r_addr[k] <= r_base[k];
              r_rem[k]  <= r_reload[k];
              if (r_reload[k] == '0) r_en[k] <= 1'b0;
            end else begin
              r_addr[k] <= r_addr[k] + 30'd1;
              r_rem[k]  <= '0;
              r_en[k]   <= 1'b0;
            end
          end else begin
            r_addr[k] <= r_addr[k] + 30'd1;
            r_rem[k]  <= r_rem[k] - C_REM_ONE;
          end
        end
      end
    end
  end

  assign csr_do          = r_csr_do;
  assign irq             = r_irq;
  assign down_addr_valid = r_down_av;
  assign down_addr       = r_down_a;
  assign down_data_valid = r_down_dv;
  assign down_data       = r_down_d;
  assign dma_en          = r_en;

  for (genvar k = 0; k < channels; k++) begin : g_dma
    assign dma_addr[30*k +: 30]                = r_addr[k];
    assign dma_remaining[count_w*k +: count_w] = r_rem[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_ac97_ctlif_mc.sv
`default_nettype none
// tb_ac97_ctlif_mc : directed checks of codec access, IRQ and DMA channel behaviour.
module tb_ac97_ctlif_mc;

  logic        clk, rst_n;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di, csr_do;
  logic        irq;
  logic        down_en, down_next_frame, down_addr_valid, down_data_valid;
  logic [19:0] down_addr, down_data;
  logic        up_en, up_next_frame, up_frame_valid, up_addr_valid, up_data_valid;
  logic [19:0] up_addr, up_data;
  logic [1:0]  dma_en, dma_next;
  logic [59:0] dma_addr;
  logic [31:0] dma_remaining;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rdv;

  ac97_ctlif_mc dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do), .irq(irq),
    .down_en(down_en), .down_next_frame(down_next_frame),
    .down_addr_valid(down_addr_valid), .down_data_valid(down_data_valid),
    .down_addr(down_addr), .down_data(down_data),
    .up_en(up_en), .up_next_frame(up_next_frame), .up_frame_valid(up_frame_valid),
    .up_addr_valid(up_addr_valid), .up_data_valid(up_data_valid),
    .up_addr(up_addr), .up_data(up_data),
    .dma_en(dma_en), .dma_addr(dma_addr), .dma_remaining(dma_remaining), .dma_next(dma_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr_nxt(input logic [13:0] a, input logic [31:0] d, input logic [1:0] nxt);
    @(negedge clk);
    csr_a = a; csr_di = d; csr_we = 1'b1; dma_next = nxt;
    @(negedge clk);
    csr_we = 1'b0; dma_next = 2'b00;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    wr_nxt(a, d, 2'b00);
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_a = a; csr_we = 1'b0;
    @(posedge clk);
    #1 d = csr_do;
  endtask

  task automatic pulse(input logic [1:0] m);
    @(negedge clk);
    dma_next = m;
    @(negedge clk);
    dma_next = 2'b00;
  endtask

  task automatic down_strobe();
    @(negedge clk);
    down_en = 1'b1; down_next_frame = 1'b1;
    @(negedge clk);
    down_en = 1'b0; down_next_frame = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; csr_a = '0; csr_we = 1'b0; csr_di = '0;
    down_en = 1'b0; down_next_frame = 1'b0;
    up_en = 1'b0; up_next_frame = 1'b0; up_frame_valid = 1'b0;
    up_addr_valid = 1'b0; up_data_valid = 1'b0; up_addr = '0; up_data = '0;
    dma_next = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_csr_do", csr_do, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_dma_en", 32'(dma_en), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Codec write request
    wr(14'h001, 32'h26);
    wr(14'h002, 32'hABCD);
    wr(14'h000, 32'h3);
    down_strobe();
    check("down_addr", 32'(down_addr), 32'h26000);
    check("down_data", 32'(down_data), 32'hABCD0);
    check("down_av", 32'(down_addr_valid), 32'h1);
    check("down_dv", 32'(down_data_valid), 32'h1);
    rd(14'h004, rdv); check("status_sent", rdv, 32'h1);
    rd(14'h000, rdv); check("ctl_after_send", rdv, 32'h2);
    down_strobe();
    check("idle_down_av", 32'(down_addr_valid), 32'h0);
    check("idle_down_addr", 32'(down_addr), 32'h0);

    // Same-cycle ctl write and frame strobe: the write keeps pending set
    @(negedge clk);
    csr_a = 14'h000; csr_di = 32'h1; csr_we = 1'b1; down_en = 1'b1; down_next_frame = 1'b1;
    @(negedge clk);
    csr_we = 1'b0; down_en = 1'b0; down_next_frame = 1'b0;
    rd(14'h000, rdv); check("pending_wins", rdv, 32'h1);

    // Codec reply and interrupt
    wr(14'h005, 32'h2);
    @(negedge clk);
    up_en = 1'b1; up_next_frame = 1'b1; up_frame_valid = 1'b1;
    up_addr_valid = 1'b1; up_data_valid = 1'b1; up_data = 20'h12340;
    @(negedge clk);
    up_en = 1'b0; up_next_frame = 1'b0; up_frame_valid = 1'b0;
    up_addr_valid = 1'b0; up_data_valid = 1'b0; up_data = '0;
    rd(14'h003, rdv); check("reply_data", rdv, 32'h1234);
    check("irq_reply", 32'(irq), 32'h1);
    wr(14'h004, 32'h2);
    rd(14'h004, rdv); check("status_after_w1c", rdv, 32'h1);
    check("irq_cleared", 32'(irq), 32'h0);

    // One-shot channel 0
    wr(14'h011, 32'h1000);
    wr(14'h012, 32'h8);
    wr(14'h010, 32'h1);
    check("ch0_en", 32'(dma_en), 32'h1);
    check("ch0_addr_word", 32'(dma_addr[29:0]), 32'h400);
    pulse(2'b01);
    check("ch0_addr_step", 32'(dma_addr[29:0]), 32'h401);
    check("ch0_rem_step", 32'(dma_remaining[15:0]), 32'h1);
    pulse(2'b01);
    rd(14'h011, rdv); check("ch0_addr_done", rdv, 32'h1008);
    rd(14'h012, rdv); check("ch0_rem_done", rdv, 32'h0);
    rd(14'h010, rdv); check("ch0_ctl_done", rdv, 32'h0);
    rd(14'h004, rdv); check("ch0_status", rdv, 32'h5);
    wr(14'h004, 32'hF);
    pulse(2'b01);
    rd(14'h011, rdv); check("ch0_idle_addr", rdv, 32'h1008);
    rd(14'h004, rdv); check("ch0_idle_status", rdv, 32'h0);

    // Looping channel 1, one word per wrap
    wr(14'h015, 32'h2000);
    wr(14'h016, 32'h4);
    wr(14'h014, 32'h3);
    for (int i = 0; i < 3; i++) begin
      pulse(2'b10);
      rd(14'h004, rdv); check("ch1_wrap_status", rdv, 32'h8);
      wr(14'h004, 32'h8);
    end
    rd(14'h015, rdv); check("ch1_addr", rdv, 32'h2000);
    rd(14'h016, rdv); check("ch1_rem", rdv, 32'h4);
    rd(14'h017, rdv); check("ch1_base", rdv, 32'h2000);
    check("ch1_en", 32'(dma_en), 32'h2);
    check("ch1_dma_addr", 32'(dma_addr[59:30]), 32'h800);
    check("ch1_dma_rem", 32'(dma_remaining[31:16]), 32'h1);

    // Collisions
    wr(14'h012, 32'h10);
    wr(14'h010, 32'h1);
    wr_nxt(14'h012, 32'h40, 2'b01);
    rd(14'h012, rdv); check("wr_beats_next", rdv, 32'h40);
    wr(14'h012, 32'h4);
    wr_nxt(14'h004, 32'h4, 2'b01);
    rd(14'h004, rdv); check("set_beats_w1c", rdv, 32'h4);

    // Asynchronous reset with channel 1 running
    wr(14'h005, 32'h4);
    rd(14'h016, rdv);
    check("pre_rst_irq", 32'(irq), 32'h1);
    check("pre_rst_en", 32'(dma_en), 32'h2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dma_en", 32'(dma_en), 32'h0);
    check("arst_dma_addr", dma_addr[31:0] | {4'h0, dma_addr[59:32]}, 32'h0);
    check("arst_dma_rem", dma_remaining, 32'h0);
    check("arst_csr_do", csr_do, 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_down", {12'h0, down_addr} | {12'h0, down_data} |
          32'({down_addr_valid, down_data_valid}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ac97_ctlif_mc.md
AC97_CTLIF_MC -- requirements
Module: ac97_ctlif_mc

Interface
REQ-001 SHALL have parameter csr_addr, default 4'h0, meaning CSR bank select matched against csr_a[13:10].
REQ-002 SHALL have parameter channels, default 2, meaning number of DMA channels; legal range 1..8.
REQ-003 SHALL have parameter count_w, default 16, meaning width of each channel's remaining-words counter; legal range 8..30.
REQ-004 SHALL have these ports:
- sys_clk  in  1  single clock; all state on rising edge.
- sys_rst_n  in  1  reset; asynchronous, active-low.
- csr_a  in  14  CSR address.
- csr_we  in  1  CSR write strobe.
- csr_di  in  32  CSR write data.
- csr_do  out  32  CSR read data, registered.
- irq  out  1  combined masked interrupt, registered.
- down_en, down_next_frame  in  1 each  downstream slot strobe.
- down_addr_valid, down_data_valid  out  1 each  slot 1/2 tags.
- down_addr, down_data  out  20 each  slot 1/2 payload.
- up_en, up_next_frame, up_frame_valid, up_addr_valid, up_data_valid  in  1 each  upstream frame status.
- up_addr, up_data  in  20 each  upstream slot 1/2 payload.
- dma_en  out  channels  per-channel enable.
- dma_addr  out  channels*30  per-channel word address; channel k at [30k+29:30k].
- dma_remaining  out  channels*count_w  per-channel remaining words.
- dma_next  in  channels  per-channel one-word-transferred pulse.

Function
REQ-005 SHALL select the bank when csr_a[13:10]==csr_addr, decode word offset csr_a[9:0], and drive csr_do with the register value one cycle after the access, or 0 when the bank is not selected or the offset is unmapped.
REQ-006 SHALL implement the global map:
- 0x000 ctl: bit0 request pending (R/W), bit1 write flag.
- 0x001 request_addr[6:0].
- 0x002 request_data[15:0].
- 0x003 reply_data[15:0], read-only.
- 0x004 irq status, write-1-to-clear.
- 0x005 irq mask.
REQ-007 SHALL implement, per channel k, the map at 0x010+4k:
- +0 ctl: bit0 en, bit1 loop.
- +1 addr: byte address; write loads csr_di[31:2] into both current and base address; read returns {current,2'b00}.
- +2 remaining: bytes; write loads csr_di[count_w+1:2] into both current and reload count; read returns {current,2'b00}.
- +3 base: read-only, returns {base address,2'b00}.
REQ-008 SHALL define irq status bits as: bit0 codec request sent, bit1 codec reply received, bit 2+k channel k finished; all other bits read 0.
REQ-009 SHALL, on down_en&down_next_frame, present down_addr_valid=pending, down_addr=pending ? {~write,addr,12'd0} : 0, down_data_valid=pending&write, down_data=(pending&write) ? {data,4'd0} : 0, and clear pending; when pending was set, SHALL also set status bit0.
REQ-010 SHALL, on up_en&up_next_frame&up_frame_valid&up_addr_valid&up_data_valid, capture reply_data=up_data[19:4] and set status bit1.
REQ-011 SHALL, on dma_next[k] with remaining>1, increment addr by 1 and decrement remaining by 1.
REQ-012 SHALL, on dma_next[k] with remaining==1 and loop=0, advance addr, set remaining=0, clear en, and set status bit 2+k.
REQ-013 SHALL, on dma_next[k] with remaining==1 and loop=1, set addr=base and remaining=reload, keep en, and set status bit 2+k; if reload==0, en SHALL also be cleared.
REQ-014 SHALL ignore dma_next[k] when remaining==0: no wrap, no status.
REQ-015 SHALL give a CSR write to a channel register priority over a same-cycle dma_next on that channel.
REQ-016 SHALL give a same-cycle status set event priority over a W1C clear of the same bit.
REQ-017 SHALL give a same-cycle CSR write of ctl bit0 priority over the frame-strobe clear of pending.
REQ-018 SHALL drive irq = |(status & mask), registered with one cycle latency.

Reset
REQ-019 SHALL, while sys_rst_n=0, asynchronously clear every register and output to 0: csr_do, irq, down_*, dma_en, dma_addr, dma_remaining, pending, status, mask, base, reload, and reply_data.

Verification
REQ-020 Codec write: write 0x001=0x26, 0x002=0xABCD, 0x000=3, then strobe down frame -> down_addr=0x26000, down_data=0xABCD0, both valids=1; status=0x1; ctl reads 0x2.
REQ-021 Reply: up frame with all valids and up_data=0x12340 -> reply_data reads 0x1234; with mask=0x2, irq=1 two cycles later; writing 0x2 to 0x004 -> irq=0.
REQ-022 One-shot channel 0: addr=0x1000, remaining=8 bytes, en=1, two dma_next -> addr reads 0x1008, remaining 0, en 0, status bit2=1; a third dma_next -> no change.
REQ-023 Loop channel 1: addr=0x2000, remaining=4, ctl=3, three dma_next -> after the last, addr=0x2000, remaining=4, en=1, status bit3 set once per wrap.
REQ-024 Collision: dma_next[0] in the same cycle as a write of remaining=0x40 -> remaining reads 0x40; W1C coincident with a finish event -> bit stays set.
REQ-025 Reset mid-transfer: assert sys_rst_n=0 asynchronously with channel active -> all outputs 0 without a clock edge.
